imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Instruction-fetch sequencer for the 128-word instruction memory. Owns the PC and drives the memory address. Captures the returned instruction into the IF/ID register. Handles stall, branch/jump redirect with flush, halt/resume, and range or alignment faults. Sits between the instruction memory and the decode stage of the MIPS pipeline.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
MEM_WORDS, 128, number of instruction words; the legal PC range is 0 to MEM_WORDS*4-4.
NOP_WORD, 32'h00000000, instruction presented when the IF/ID slot is invalid.

Ports:
Clk  input  1  system clock; all state updates on its rising edge.
Reset  input  1  synchronous, active-high reset.
Stall  input  1  hazard stall from decode; holds the PC and IF/ID registers.
Redirect  input  1  branch/jump taken this cycle.
RedirectAddr  input  32  target PC for Redirect.
HaltReq  input  1  request to stop fetching.
Resume  input  1  leave HALT.
IMemAddress  output  32  address to the instruction memory, combinational copy of the PC.
IMemInstruction  input  32  combinational read data from the instruction memory.
IF_Instruction  output  32  IF/ID instruction register.
IF_PC  output  32  PC of IF_Instruction.
IF_PCPlus4  output  32  IF_PC+4.
IF_Valid  output  1  IF/ID slot holds a real instruction.
Halted  output  1  high while in HALT.
Fault  output  1  high while in FAULT.
FaultAddr  output  32  offending address.
FetchCount  output  32  number of instructions issued with IF_Valid=1.

Behaviour:
- Reset
  - Reset overrides every other input.
  - State=BOOT, PC=RESET_PC.
  - IF_Instruction=NOP_WORD, IF_PC=0, IF_PCPlus4=0, IF_Valid=0.
  - Halted=0, Fault=0, FaultAddr=0, FetchCount=0.
- Memory interface
  - IMemAddress = PC at all times.
  - The memory read is combinational, so the instruction is captured at the end of the same cycle. Fetch latency is 1 cycle from PC to IF/ID.
- BOOT
  - Lasts exactly 1 cycle; IF_Valid stays 0 and the PC is unchanged.
  - Next state is RUN.
- RUN: per cycle, highest priority first.
  1. Redirect=1:
     - If RedirectAddr[1:0]!=0 or RedirectAddr>=MEM_WORDS*4: FAULT, FaultAddr=RedirectAddr.
     - Otherwise PC<=RedirectAddr and the IF/ID slot is flushed (IF_Valid<=0, IF_Instruction<=NOP_WORD).
     - Redirect overrides Stall.
     - If HaltReq is also 1, the PC still takes the target and the next state is HALT.
  2. HaltReq=1: PC held, slot flushed, next state HALT. The instruction fetched this cycle is discarded and refetched after Resume.
  3. Stall=1: PC, IF/ID registers and FetchCount all held.
  4. Otherwise, PC range check:
     - If PC>=MEM_WORDS*4: FAULT, FaultAddr=PC, slot flushed.
     - Else: IF_Instruction<=IMemInstruction, IF_PC<=PC, IF_PCPlus4<=PC+4, IF_Valid<=1, PC<=PC+4, FetchCount<=FetchCount+1.
- HALT
  - Halted=1; PC frozen; IF_Valid=0. Stall, Redirect and HaltReq are ignored.
  - Resume=1: next state RUN, Halted=0 next cycle, and fetch restarts from the held PC.
- FAULT
  - Fault=1, sticky; IF_Valid=0; PC frozen.
  - Only Reset leaves FAULT.
- Arithmetic
  - PC+4 is 32-bit modulo.
  - FetchCount wraps from 32'hFFFFFFFF to 0.
- Wrap boundary
  - Fetch at PC=4*MEM_WORDS-4 is issued normally.
  - The following sequential fetch faults with FaultAddr=4*MEM_WORDS.
  - The PC never silently wraps to 0.
- Mid-operation reset
  - Reset asserted in any state returns to BOOT next edge with all reset values, regardless of Stall, Redirect or HaltReq.

Test Plan:
- Reset, then 6 free-run cycles, memory preloaded with word i = i*3 -> BOOT cycle with IF_Valid=0; then IF_PC=0,4,8,12,16 with IF_Instruction=0,3,6,9,12; FetchCount=5.
- Stall held for 3 cycles at PC=0x10 -> IF_PC stays 0x0C, IF_Instruction stays 9, IMemAddress stays 0x10, FetchCount unchanged; after release the next IF_PC is 0x10.
- Redirect with RedirectAddr=0x40 while Stall=1 -> next cycle IF_Valid=0 and IMemAddress=0x40; following cycle IF_PC=0x40, IF_Instruction=48.
- Redirect with RedirectAddr=0x42, and separately RedirectAddr=0x200 -> Fault=1 with FaultAddr=0x42 (respectively 0x200), IF_Valid=0 thereafter; only Reset clears it.
- Free-run to PC=0x1FC -> 0x1FC issued valid with instruction 381; next cycle Fault=1, FaultAddr=0x200.
- HaltReq at PC=0x20, then 4 idle cycles, then Resume -> Halted=1 and IF_Valid=0 during the halt; after Resume, the first valid IF_PC is 0x20. Reset asserted mid-HALT -> BOOT with FetchCount=0.

Source files
------------

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives the instruction memory address and
// loads the IF/ID register, with stall, redirect/flush, halt/resume and range/alignment faults.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter int          MEM_WORDS = 128,
  parameter logic [31:0] NOP_WORD  = 32'h00000000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  input  logic        HaltReq,
  input  logic        Resume,
  output logic [31:0] IMemAddress,
  input  logic [31:0] IMemInstruction,
  output logic [31:0] IF_Instruction,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_PCPlus4,
  output logic        IF_Valid,
  output logic        Halted,
  output logic        Fault,
  output logic [31:0] FaultAddr,
  output logic [31:0] FetchCount
);

  localparam logic [31:0] PC_LIMIT = 32'(MEM_WORDS * 4);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALT,
    S_FAULT
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] if_instr_reg, if_instr_next;
  logic [31:0] if_pc_reg, if_pc_next;
  logic [31:0] if_pcp4_reg, if_pcp4_next;
  logic        if_valid_reg, if_valid_next;
  logic [31:0] fault_addr_reg, fault_addr_next;
  logic [31:0] fetch_count_reg, fetch_count_next;

  logic [31:0] pc_plus4;
  logic        redirect_bad;

  assign pc_plus4     = pc_reg + 32'd4;
  assign redirect_bad = (RedirectAddr[1:0] != 2'b00) || (RedirectAddr >= PC_LIMIT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg       <= S_BOOT;
      pc_reg          <= RESET_PC;
      if_instr_reg    <= NOP_WORD;
      if_pc_reg       <= 32'd0;
      if_pcp4_reg     <= 32'd0;
      if_valid_reg    <= 1'b0;
      fault_addr_reg  <= 32'd0;
      fetch_count_reg <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      if_instr_reg    <= if_instr_next;
      if_pc_reg       <= if_pc_next;
      if_pcp4_reg     <= if_pcp4_next;
      if_valid_reg    <= if_valid_next;
      fault_addr_reg  <= fault_addr_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    if_instr_next    = if_instr_reg;
    if_pc_next       = if_pc_reg;
    if_pcp4_next     = if_pcp4_reg;
    if_valid_next    = if_valid_reg;
    fault_addr_next  = fault_addr_reg;
    fetch_count_next = fetch_count_reg;

    case (state_reg)
      S_BOOT: begin
        state_next = S_RUN;
      end

      S_RUN: begin
        if (Redirect) begin
          // A taken redirect always empties the slot; a bad target faults instead of jumping.
          if_valid_next = 1'b0;
          if_instr_next = NOP_WORD;
          if (redirect_bad) begin
            state_next      = S_FAULT;
            fault_addr_next = RedirectAddr;
          end else begin
            pc_next = RedirectAddr;
            if (HaltReq) state_next = S_HALT;
          end
        end else if (HaltReq) begin
          // The word fetched this cycle is dropped; the held PC refetches it after Resume.
          if_valid_next = 1'b0;
          if_instr_next = NOP_WORD;
          state_next    = S_HALT;
        end else if (!Stall) begin
          if (pc_reg >= PC_LIMIT) begin
            state_next      = S_FAULT;
            fault_addr_next = pc_reg;
            if_valid_next   = 1'b0;
            if_instr_next   = NOP_WORD;
          end else begin
            if_instr_next    = IMemInstruction;
            if_pc_next       = pc_reg;
            if_pcp4_next     = pc_plus4;
            if_valid_next    = 1'b1;
            pc_next          = pc_plus4;
            fetch_count_next = fetch_count_reg + 32'd1;
          end
        end
      end

      S_HALT: begin
        if (Resume) state_next = S_RUN;
      end

      S_FAULT: begin
        state_next = S_FAULT;
      end

      default: begin
        state_next = S_BOOT;
      end
    endcase
  end

  assign IMemAddress    = pc_reg;
  assign IF_Instruction = if_instr_reg;
  assign IF_PC          = if_pc_reg;
  assign IF_PCPlus4     = if_pcp4_reg;
  assign IF_Valid       = if_valid_reg;
  assign Halted         = (state_reg == S_HALT);
  assign Fault          = (state_reg == S_FAULT);
  assign FaultAddr      = fault_addr_reg;
  assign FetchCount     = fetch_count_reg;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a table of per-cycle vectors plus hand-written
// sequences for faults, the top-of-memory boundary and reset during HALT.
module tb_imem_fetch_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Stall;
  logic        Redirect;
  logic [31:0] RedirectAddr;
  logic        HaltReq;
  logic        Resume;
  logic [31:0] IMemAddress;
  logic [31:0] IMemInstruction;
  logic [31:0] IF_Instruction;
  logic [31:0] IF_PC;
  logic [31:0] IF_PCPlus4;
  logic        IF_Valid;
  logic        Halted;
  logic        Fault;
  logic [31:0] FaultAddr;
  logic [31:0] FetchCount;

  int n_total = 0;
  int n_pass  = 0;

  always #5 Clk = ~Clk;

  // Memory model: word i holds i*3; out-of-range reads return a distinctive pattern.
  assign IMemInstruction = (IMemAddress < 32'd512) ? {23'd0, IMemAddress[10:2]} * 32'd3
                                                   : 32'hDEADBEEF;

  imem_fetch_ctrl #(
    .RESET_PC (32'h00000000),
    .MEM_WORDS(128),
    .NOP_WORD (32'h00000000)
  ) dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .Stall          (Stall),
    .Redirect       (Redirect),
    .RedirectAddr   (RedirectAddr),
    .HaltReq        (HaltReq),
    .Resume         (Resume),
    .IMemAddress    (IMemAddress),
    .IMemInstruction(IMemInstruction),
    .IF_Instruction (IF_Instruction),
    .IF_PC          (IF_PC),
    .IF_PCPlus4     (IF_PCPlus4),
    .IF_Valid       (IF_Valid),
    .Halted         (Halted),
    .Fault          (Fault),
    .FaultAddr      (FaultAddr),
    .FetchCount     (FetchCount)
  );

  typedef struct {
    logic        stall;
    logic        redir;
    logic [31:0] raddr;
    logic        halt;
    logic        resume;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] einstr;
    logic [31:0] eaddr;
    logic        ehalt;
    logic        efault;
    logic [31:0] efaddr;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(logic st, logic rd, logic [31:0] ra, logic hr, logic rs,
                              logic ev, logic [31:0] epc, logic [31:0] ei, logic [31:0] ea,
                              logic eh, logic ef, logic [31:0] efa, logic [31:0] ec);
    vec_t v;
    v.stall = st; v.redir = rd; v.raddr = ra; v.halt = hr; v.resume = rs;
    v.ev = ev; v.epc = epc; v.einstr = ei; v.eaddr = ea;
    v.ehalt = eh; v.efault = ef; v.efaddr = efa; v.ecnt = ec;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(logic st, logic rd, logic [31:0] ra, logic hr, logic rs);
    Stall = st; Redirect = rd; RedirectAddr = ra; HaltReq = hr; Resume = rs;
  endtask

  // Advance one edge and settle just past it.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_state(string tag, logic ev, logic [31:0] epc, logic [31:0] ei,
                             logic [31:0] ea, logic eh, logic ef, logic [31:0] efa,
                             logic [31:0] ec);
    chk({tag, ".valid"}, {31'd0, IF_Valid}, {31'd0, ev});
    chk({tag, ".instr"}, IF_Instruction, ev ? ei : 32'h0);
    if (ev) begin
      chk({tag, ".if_pc"}, IF_PC, epc);
      chk({tag, ".if_pc4"}, IF_PCPlus4, epc + 32'd4);
    end
    chk({tag, ".imem_addr"}, IMemAddress, ea);
    chk({tag, ".halted"}, {31'd0, Halted}, {31'd0, eh});
    chk({tag, ".fault"}, {31'd0, Fault}, {31'd0, ef});
    chk({tag, ".fault_addr"}, FaultAddr, efa);
    chk({tag, ".fetch_count"}, FetchCount, ec);
    $display("%s: valid=%0d if_pc=0x%03h instr=%0d addr=0x%03h halted=%0d fault=%0d faddr=0x%03h count=%0d",
             tag, IF_Valid, IF_PC, IF_Instruction, IMemAddress, Halted, Fault, FaultAddr, FetchCount);
  endtask

  task automatic do_reset(string tag);
    Reset = 1'b1;
    step();
    step();
    check_state(tag, 1'b0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk({tag, ".if_pc_rst"}, IF_PC, 32'd0);
    chk({tag, ".if_pc4_rst"}, IF_PCPlus4, 32'd0);
    Reset = 1'b0;
  endtask

  initial begin
    // Free run, stall, redirect under stall, halt with ignored inputs, resume, bad redirect.
    vecs[0]  = mk(0,0,0,     0,0, 0,0,    0, 32'h00,0,0,0,    0);
    vecs[1]  = mk(0,0,0,     0,0, 1,0,    0, 32'h04,0,0,0,    1);
    vecs[2]  = mk(0,0,0,     0,0, 1,4,    3, 32'h08,0,0,0,    2);
    vecs[3]  = mk(0,0,0,     0,0, 1,8,    6, 32'h0C,0,0,0,    3);
    vecs[4]  = mk(0,0,0,     0,0, 1,12,   9, 32'h10,0,0,0,    4);
    vecs[5]  = mk(1,0,0,     0,0, 1,12,   9, 32'h10,0,0,0,    4);
    vecs[6]  = mk(1,0,0,     0,0, 1,12,   9, 32'h10,0,0,0,    4);
    vecs[7]  = mk(1,0,0,     0,0, 1,12,   9, 32'h10,0,0,0,    4);
    vecs[8]  = mk(0,0,0,     0,0, 1,16,  12, 32'h14,0,0,0,    5);
    vecs[9]  = mk(1,1,32'h40,0,0, 0,0,    0, 32'h40,0,0,0,    5);
    vecs[10] = mk(0,0,0,     0,0, 1,32'h40,48,32'h44,0,0,0,   6);
    vecs[11] = mk(0,1,32'h20,0,0, 0,0,    0, 32'h20,0,0,0,    6);
    vecs[12] = mk(0,0,0,     1,0, 0,0,    0, 32'h20,1,0,0,    6);
    vecs[13] = mk(1,0,0,     0,0, 0,0,    0, 32'h20,1,0,0,    6);
    vecs[14] = mk(0,1,32'h100,0,0,0,0,    0, 32'h20,1,0,0,    6);
    vecs[15] = mk(0,0,0,     1,0, 0,0,    0, 32'h20,1,0,0,    6);
    vecs[16] = mk(0,0,0,     0,0, 0,0,    0, 32'h20,1,0,0,    6);
    vecs[17] = mk(0,0,0,     0,1, 0,0,    0, 32'h20,0,0,0,    6);
    vecs[18] = mk(0,0,0,     0,0, 1,32'h20,24,32'h24,0,0,0,   7);
    vecs[19] = mk(0,1,32'h42,0,0, 0,0,    0, 32'h24,0,1,32'h42,7);
    vecs[20] = mk(0,1,32'h40,0,1, 0,0,    0, 32'h24,0,1,32'h42,7);
    vecs[21] = mk(0,0,0,     0,0, 0,0,    0, 32'h24,0,1,32'h42,7);

    Reset = 1'b1;
    drive(0, 0, 32'd0, 0, 0);
    do_reset("reset");

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].stall, vecs[i].redir, vecs[i].raddr, vecs[i].halt, vecs[i].resume);
      step();
      check_state($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].einstr,
                  vecs[i].eaddr, vecs[i].ehalt, vecs[i].efault, vecs[i].efaddr, vecs[i].ecnt);
    end

    // Out-of-range redirect faults; fault is sticky until reset.
    drive(0, 0, 32'd0, 0, 0);
    do_reset("rst2");
    step();
    check_state("boot2", 0, 0, 0, 32'h0, 0, 0, 0, 0);
    drive(0, 1, 32'h200, 0, 0);
    step();
    check_state("redir200", 0, 0, 0, 32'h0, 0, 1, 32'h200, 0);
    drive(0, 0, 32'd0, 0, 1);
    step();
    step();
    check_state("fault_sticky", 0, 0, 0, 32'h0, 0, 1, 32'h200, 0);
    drive(0, 0, 32'd0, 0, 0);
    do_reset("rst3");

    // Redirect with HaltReq: PC takes target and halts; then run off the top of memory.
    step();
    drive(0, 1, 32'h1F0, 1, 0);
    step();
    check_state("redir_halt", 0, 0, 0, 32'h1F0, 1, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 1);
    step();
    check_state("resume2", 0, 0, 0, 32'h1F0, 0, 0, 0, 0);
    drive(0, 0, 32'd0, 0, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check_state($sformatf("top%0d", k), 1, 32'h1F0 + 32'(4 * k), 32'(372 + 3 * k),
                  32'h1F4 + 32'(4 * k), 0, 0, 0, 32'(k + 1));
    end
    step();
    check_state("wrap_fault", 0, 0, 0, 32'h200, 0, 1, 32'h200, 4);

    // Reset asserted during HALT, with every other control input active.
    do_reset("rst4");
    step();
    step();
    step();
    check_state("pre_halt", 1, 32'h4, 3, 32'h8, 0, 0, 0, 2);
    drive(0, 0, 32'd0, 1, 0);
    step();
    check_state("halted", 0, 0, 0, 32'h8, 1, 0, 0, 2);
    Reset = 1'b1;
    drive(1, 1, 32'h40, 1, 1);
    step();
    check_state("rst_in_halt", 0, 0, 0, 32'h0, 0, 0, 0, 0);
    Reset = 1'b0;
    drive(0, 0, 32'd0, 0, 0);
    step();
    check_state("boot4", 0, 0, 0, 32'h0, 0, 0, 0, 0);
    step();
    check_state("first4", 1, 32'h0, 0, 32'h4, 0, 0, 0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
